conv_result_streamer: RTL

Downstream stage of the convolution datapath/controller pair. On the rising edge of the controller's done flag, it snapshots the 15 signed 19-bit convolution results C1..C15. It then streams them out one per beat, C1 first, over a valid/ready interface to the next consumer (output FIFO or UART framer). This decouples the consumer from the convolution core, whose outputs stay live only while done is held.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_result_streamer.sv | 104 ++++++++++
 2 files changed

// File: rtl/conv_pkg.sv
// Shared constants, state encoding and bus-slicing helper for the convolution
// result path.
package conv_pkg;

  localparam int unsigned CONV_W     = 19;
  localparam int unsigned CONV_N_OUT = 15;
  localparam int unsigned CONV_IDX_W = 4;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } conv_state_e;

  // Result k (0-based, 0 = C1) out of the packed results bus.
  function automatic logic [CONV_W-1:0] conv_slice(
    input logic [CONV_N_OUT*CONV_W-1:0] bus,
    input logic [CONV_IDX_W-1:0]        k
  );
    return bus[k*CONV_W +: CONV_W];
  endfunction

endpackage

// File: rtl/conv_result_streamer.sv
// Snapshots the convolution results on the rising edge of done and streams
// them out C1 first over a valid/ready interface.
module conv_result_streamer
  import conv_pkg::*;
#(
  parameter int unsigned N_OUT = CONV_N_OUT,
  parameter int unsigned W     = CONV_W,
  parameter int unsigned IDX_W = CONV_IDX_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               done,
  input  logic [N_OUT*W-1:0] conv_bus,
  output logic [W-1:0]       out_data,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy,
  output logic               overrun,
  output logic [7:0]         frame_count
);

  conv_state_e        state_q, state_d;
  logic [N_OUT*W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q;
  logic               overrun_q, overrun_d;
  logic [7:0]         frame_count_q, frame_count_d;

  logic start;
  logic at_last;
  logic xfer;

  assign start   = done & ~done_q;
  assign at_last = (idx_q == IDX_W'(N_OUT - 1));
  assign xfer    = (state_q == ST_STREAM) & out_ready;

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    idx_d         = idx_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          buf_d   = conv_bus;
          idx_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (xfer && at_last) begin
          frame_count_d = frame_count_q + 8'd1;
          idx_d         = '0;
          // A start coinciding with the final beat chains straight into the next frame.
          if (start) begin
            buf_d = conv_bus;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (start) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      buf_q         <= '0;
      idx_q         <= '0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      idx_q         <= idx_d;
      done_q        <= done;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Outputs depend on registered state only, so out_ready never reaches them combinationally.
  assign out_valid   = (state_q == ST_STREAM);
  assign busy        = (state_q == ST_STREAM);
  assign out_last    = (state_q == ST_STREAM) & at_last;
  assign out_index   = idx_q;
  assign out_data    = conv_slice(buf_q, idx_q);
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule
